// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU front-end arbiter: opcode encodings,
// controller state enum and two small opcode classification helpers.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b1001;
    localparam logic [3:0] OP_SHR = 4'b1010;
    localparam logic [3:0] OP_INC = 4'b1011;
    localparam logic [3:0] OP_DEC = 4'b1100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // A divide or modulo by zero is rejected before it reaches the ALU.
    function automatic logic is_div_zero(input logic [3:0] op, input logic [7:0] b);
        return ((op == OP_DIV) || (op == OP_MOD)) && (b == 8'd0);
    endfunction

    // Only add and subtract produce a meaningful carry/borrow flag.
    function automatic logic keeps_carry(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on contention it grants the requester that
// did not win last time; with a single requester it grants that one.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic       grant,
    output logic       any_valid
);

    // Choose the grant index from the current valid pattern and last winner.
    always_comb begin
        grant = 1'b0;
        if (valid == 2'b11) begin
            grant = ~last;
        end else if (valid[1]) begin
            grant = 1'b1;
        end
    end

    assign any_valid = |valid;

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one registered-output ALU. A job is
// accepted in IDLE, its operands are held on alu_* while the ALU computes,
// and the result is presented on rsp_* until the consumer takes it.
//
// Handshake: a requester's job transfers on a rising edge where
// reqN_valid && reqN_ready; the response transfers on a rising edge where
// rsp_valid && rsp_ready. Ready is only ever offered in IDLE and never
// depends on the same requester deasserting valid afterwards.
module alu_arbiter
    import alu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [3:0]  req0_opcode,
    input  logic [3:0]  req1_opcode,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_opcode,
    input  logic [7:0]  alu_op,
    input  logic        alu_carry,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_data,
    output logic        rsp_carry,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic [15:0] txn_count
);

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic       grant_idx;
    logic       any_valid;
    logic       accept;
    logic       sel_err;
    logic [3:0] sel_opcode;
    logic [7:0] sel_a;
    logic [7:0] sel_b;

    rr_pick2 u_pick (
        .valid     ({req1_valid, req0_valid}),
        .last      (last_grant),
        .grant     (grant_idx),
        .any_valid (any_valid)
    );

    assign sel_opcode = grant_idx ? req1_opcode : req0_opcode;
    assign sel_a      = grant_idx ? req1_a      : req0_a;
    assign sel_b      = grant_idx ? req1_b      : req0_b;
    assign sel_err    = is_div_zero(sel_opcode, sel_b);
    assign accept     = (state == IDLE) && any_valid;
    assign rsp_valid  = (state == RESP);

    // Next-state and ready decode; ready goes only to the granted requester.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    req0_ready = ~grant_idx;
                    req1_ready = grant_idx;
                    state_nxt  = sel_err ? RESP : ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset drops any in-flight job.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand, grant and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            alu_a      <= 8'd0;
            alu_b      <= 8'd0;
            alu_opcode <= OP_ADD;
            rsp_id     <= 1'b0;
            rsp_data   <= 8'd0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant_idx;
                rsp_id     <= grant_idx;
                if (sel_err) begin
                    // Rejected job: the ALU keeps its previous operands.
                    rsp_data  <= 8'd0;
                    rsp_carry <= 1'b0;
                    rsp_zero  <= 1'b0;
                    rsp_err   <= 1'b1;
                end else begin
                    alu_a      <= sel_a;
                    alu_b      <= sel_b;
                    alu_opcode <= sel_opcode;
                end
            end
            if (state == WAIT) begin
                rsp_data  <= alu_op;
                rsp_zero  <= alu_zero;
                rsp_carry <= keeps_carry(alu_opcode) ? alu_carry : 1'b0;
                rsp_err   <= 1'b0;
            end
        end
    end

    // Completed-response counter, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txn_count <= 16'd0;
        end else if ((state == RESP) && rsp_ready) begin
            txn_count <= txn_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU.
module tb_alu_arbiter;
    import alu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_opcode, req1_opcode;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_op = 8'd0;
    logic        alu_carry = 1'b0;
    logic        alu_zero = 1'b0;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_carry, rsp_zero, rsp_err;
    logic [15:0] txn_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    alu_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req1_valid  (req1_valid),
        .req0_ready  (req0_ready),
        .req1_ready  (req1_ready),
        .req0_opcode (req0_opcode),
        .req1_opcode (req1_opcode),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_op      (alu_op),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_carry   (rsp_carry),
        .rsp_zero    (rsp_zero),
        .rsp_err     (rsp_err),
        .txn_count   (txn_count)
    );

    // Clock
    always #5 clk = ~clk;

    // Behavioural ALU: {carry, result}, registered on posedge.
    function automatic logic [8:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {(a < b), a - b};
            OP_MUL:  return {1'b0, a * b};
            OP_DIV:  return (b == 8'd0) ? 9'd0 : {1'b0, a / b};
            OP_MOD:  return (b == 8'd0) ? 9'd0 : {1'b0, a % b};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    always @(posedge clk) begin
        alu_op    <= alu_model(alu_opcode, alu_a, alu_b) & 9'h0FF;
        alu_carry <= alu_model(alu_opcode, alu_a, alu_b) > 9'h0FF;
        alu_zero  <= (alu_model(alu_opcode, alu_a, alu_b) & 9'h0FF) == 9'd0;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic id, input logic [7:0] data,
                           input logic cy, input logic z, input logic err);
        chk({tag, " rsp_valid"}, rsp_valid, 1);
        chk({tag, " rsp_id"},    rsp_id,    id);
        chk({tag, " rsp_data"},  rsp_data,  data);
        chk({tag, " rsp_carry"}, rsp_carry, cy);
        chk({tag, " rsp_zero"},  rsp_zero,  z);
        chk({tag, " rsp_err"},   rsp_err,   err);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " rsp_valid"},  rsp_valid,  0);
        chk({tag, " alu_a"},      alu_a,      0);
        chk({tag, " alu_b"},      alu_b,      0);
        chk({tag, " alu_opcode"}, alu_opcode, 0);
        chk({tag, " rsp_id"},     rsp_id,     0);
        chk({tag, " rsp_data"},   rsp_data,   0);
        chk({tag, " rsp_carry"},  rsp_carry,  0);
        chk({tag, " rsp_zero"},   rsp_zero,   0);
        chk({tag, " rsp_err"},    rsp_err,    0);
        chk({tag, " txn_count"},  txn_count,  0);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_opcode = OP_ADD; req1_opcode = OP_ADD;
        req0_a = 8'd0; req0_b = 8'd0; req1_a = 8'd0; req1_b = 8'd0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk_reset_vals("reset");
        chk("reset req0_ready", req0_ready, 0);
        chk("reset req1_ready", req1_ready, 0);

        // Single job: 200 + 100 = 300 -> 44 with carry
        req0_valid = 1'b1; req0_opcode = OP_ADD; req0_a = 8'd200; req0_b = 8'd100;
        #1;
        chk("single req0_ready", req0_ready, 1);
        chk("single req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("single ready drop", req0_ready, 0);
        chk("single alu_a", alu_a, 200);
        chk("single alu_b", alu_b, 100);
        chk("single alu_opcode", alu_opcode, OP_ADD);
        chk("single valid N+1", rsp_valid, 0);
        tick();
        chk("single valid N+2", rsp_valid, 0);
        tick();
        chk_rsp("single", 1'b0, 8'd44, 1'b1, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        tick();
        chk("single done valid", rsp_valid, 0);
        chk("single txn", txn_count, 1);
        rsp_ready = 1'b0;

        // Divide by zero from requester 1
        req1_valid = 1'b1; req1_opcode = OP_DIV; req1_a = 8'd9; req1_b = 8'd0;
        #1;
        chk("div0 req1_ready", req1_ready, 1);
        chk("div0 req0_ready", req0_ready, 0);
        tick();
        req1_valid = 1'b0;
        chk_rsp("div0", 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("div0 alu_a kept", alu_a, 200);
        chk("div0 alu_b kept", alu_b, 100);
        chk("div0 alu_opcode kept", alu_opcode, OP_ADD);
        rsp_ready = 1'b1;
        tick();
        chk("div0 txn", txn_count, 2);
        chk("div0 done valid", rsp_valid, 0);

        // Contention: grants alternate 0,1,0,1
        req0_valid = 1'b1; req0_opcode = OP_SUB; req0_a = 8'd5;    req0_b = 8'd5;
        req1_valid = 1'b1; req1_opcode = OP_AND; req1_a = 8'hF0;   req1_b = 8'h0F;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cont req0_ready", req0_ready, (k % 2) == 0);
            chk("cont req1_ready", req1_ready, (k % 2) == 1);
            tick();
            chk("cont alu_opcode", alu_opcode, ((k % 2) == 0) ? OP_SUB : OP_AND);
            tick();
            tick();
            chk_rsp("cont", k[0], 8'd0, 1'b0, 1'b1, 1'b0);
            chk("cont resp req0_ready", req0_ready, 0);
            chk("cont resp req1_ready", req1_ready, 0);
            tick();
            chk("cont txn", txn_count, 3 + k);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b0;

        // Backpressure on MUL 3*4
        req0_valid = 1'b1; req0_opcode = OP_MUL; req0_a = 8'd3; req0_b = 8'd4;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp rsp_valid", rsp_valid, 1);
            chk("bp rsp_data", rsp_data, 12);
            chk("bp req0_ready", req0_ready, 0);
            chk("bp req1_ready", req1_ready, 0);
            chk("bp txn held", txn_count, 6);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk("bp done valid", rsp_valid, 0);
        chk("bp txn", txn_count, 7);
        tick();
        chk("bp single increment", txn_count, 7);
        rsp_ready = 1'b0;

        // Reset while in WAIT
        req1_valid = 1'b1; req1_opcode = OP_OR; req1_a = 8'h30; req1_b = 8'h0F;
        tick();
        req1_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset_vals("midrst");
        tick();
        chk("midrst no rsp 1", rsp_valid, 0);
        tick();
        chk("midrst no rsp 2", rsp_valid, 0);

        // Wrap: preload counter to all-ones, then complete one job
        force dut.txn_count = 16'hFFFF;
        tick();
        release dut.txn_count;
        #1;
        chk("wrap preload", txn_count, 16'hFFFF);
        req0_valid = 1'b1; req0_opcode = OP_ADD; req0_a = 8'd1; req0_b = 8'd2;
        req1_valid = 1'b1; req1_opcode = OP_XOR; req1_a = 8'd7; req1_b = 8'd7;
        #1;
        chk("midrst grant req0", req0_ready, 1);
        chk("midrst grant req1", req1_ready, 0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        tick();
        chk_rsp("wrap", 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
        chk("wrap txn before", txn_count, 16'hFFFF);
        rsp_ready = 1'b1;
        tick();
        chk("wrap txn", txn_count, 0);
        chk("wrap done valid", rsp_valid, 0);
        rsp_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
